// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Fetch entries carry the instruction together with its PC.
package cpu_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of {pc, instr}, flush has priority.
// Head reads as zero whenever the buffer is empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       head_valid,
    output fetch_entry_t               head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   occ_q;
    logic            do_pop;
    logic            do_push;

    assign do_pop  = pop && (occ_q != '0) && !flush;
    assign do_push = push && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + CW'(1);
                2'b01:   occ_q <= occ_q - CW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset: an empty buffer never exposes it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign occ        = occ_q;
    assign head_valid = (occ_q != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch front end: PC, credit-limited memory requests,
// in-order response buffering and redirect flush of stale responses.
module pc_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               rsp_err
);

    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]    DEPTH_X = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] occ;
    logic          run_q;
    logic          rsp_err_q;

    logic [CW:0]   outstanding;
    logic [CW:0]   stale;
    logic [CW:0]   stale_left;
    logic          has_credit;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_push;
    logic          rsp_orphan;
    logic          fifo_pop;
    logic [31:0]   oldest_pc;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign outstanding = {1'b0, occ} + {1'b0, inflight};
    assign has_credit  = (outstanding < DEPTH_X);

    // run_q delays the first request to the cycle after reset is released.
    assign imem_req_valid = rst_n && run_q && has_credit
                         && (discard == '0) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;

    assign req_fire   = imem_req_valid && imem_req_ready;
    assign rsp_drop   = imem_rsp_valid && (discard != '0);
    assign rsp_push   = imem_rsp_valid && (discard == '0)
                     && (inflight != '0) && !redirect_valid;
    assign rsp_orphan = imem_rsp_valid && (discard == '0)
                     && (inflight == '0);

    // The oldest live request sits inflight words behind fetch_pc.
    assign oldest_pc  = fetch_pc - ({{(32-CW){1'b0}}, inflight} << 2);
    assign push_entry = '{pc: oldest_pc, instr: imem_rsp_data};

    assign stale      = {1'b0, discard} + {1'b0, inflight};
    assign stale_left = (imem_rsp_valid && (stale != '0))
                      ? stale - (CW+1)'(1) : stale;

    assign fifo_pop = instr_valid && instr_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            inflight  <= '0;
            discard   <= '0;
            rsp_err_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (rsp_orphan) begin
                rsp_err_q <= 1'b1;
            end
            if (redirect_valid) begin
                fetch_pc <= pc_align(redirect_pc);
                inflight <= '0;
                discard  <= CW'(stale_left);
            end else begin
                if (req_fire) begin
                    fetch_pc <= pc_next(fetch_pc);
                end
                if (rsp_drop) begin
                    discard <= discard - CW'(1);
                end
                case ({req_fire, rsp_push})
                    2'b10:   inflight <= inflight + CW'(1);
                    2'b01:   inflight <= inflight - CW'(1);
                    default: inflight <= inflight;
                endcase
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .occ       (occ),
        .head_valid(instr_valid),
        .head_data (head)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: queue-based reference model, in-order
// variable-latency memory, directed scenarios and random traffic.
module tb_pc_fetch_stage;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        rsp_err;

    always #5 clk = ~clk;

    pc_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .rsp_err       (rsp_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        mem_q[$];
    logic [31:0]  m_pc;
    fetch_entry_t m_fifo[$];
    logic [31:0]  m_live[$];
    int           m_discard;
    bit           m_err;
    bit           m_run;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit          d_rst_n, d_req_ready, d_instr_ready, d_redir, d_unsol;
    logic [31:0] d_redir_pc;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rsp_from_mem;
    bit          e_rv;
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        rst_n          = d_rst_n;
        imem_req_ready = d_req_ready;
        instr_ready    = d_instr_ready;
        redirect_valid = d_redir;
        redirect_pc    = d_redir_pc;
        rsp_from_mem   = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (d_unsol) begin
            imem_rsp_valid = 1'b1;
        end else if (d_rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            rsp_from_mem   = 1'b1;
        end
        #1;
        e_rv = d_rst_n && m_run && !d_redir && m_discard == 0
            && (m_fifo.size() + m_live.size() < DEPTH);
        chk1("req_valid", imem_req_valid, e_rv);
        if (e_rv) chk("req_addr", imem_req_addr, m_pc);
        chk1("instr_valid", instr_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) begin
            chk("instr", instr, m_fifo[0].instr);
            chk("instr_pc", instr_pc, m_fifo[0].pc);
        end
        chk1("rsp_err", rsp_err, m_err);
        if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
        if (instr_valid && instr_ready && !redirect_valid)
            pop_log.push_back(instr_pc);
    endtask

    task automatic end_cycle();
        bit          fire;
        logic [31:0] a;
        int          lat;
        fire = e_rv && d_req_ready;
        if (!d_rst_n) begin
            m_pc      = 32'h0;
            m_discard = 0;
            m_err     = 1'b0;
            m_run     = 1'b0;
            m_fifo.delete();
            m_live.delete();
            mem_q.delete();
        end else begin
            if (rsp_from_mem) void'(mem_q.pop_front());
            if (d_redir) begin
                int stale;
                stale = m_discard + m_live.size();
                if (imem_rsp_valid) begin
                    if (stale > 0) stale--;
                    else m_err = 1'b1;
                end
                m_discard = stale;
                m_live.delete();
                m_fifo.delete();
                m_pc = d_redir_pc & ~32'h3;
            end else begin
                if (d_instr_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
                if (imem_rsp_valid) begin
                    if (m_discard > 0) begin
                        m_discard--;
                    end else if (m_live.size() > 0) begin
                        a = m_live.pop_front();
                        m_fifo.push_back('{pc: a, instr: imem_rsp_data});
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (fire) begin
                    lat = int'($urandom_range(lat_max, lat_min));
                    m_live.push_back(m_pc);
                    mem_q.push_back('{addr: m_pc, due: cyc + lat});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = 1'b1;
        end
        cyc++;
    endtask

    task automatic tick();
        begin_cycle();
        end_cycle();
    endtask

    task automatic do_reset();
        d_rst_n = 1'b0;
        d_redir = 1'b0;
        d_unsol = 1'b0;
        tick();
        tick();
        d_rst_n = 1'b1;
        req_log.delete();
        pop_log.delete();
    endtask

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0;
        d_req_ready = 1'b1; d_instr_ready = 1'b1; d_redir_pc = '0;
        m_run = 1'b0; m_err = 1'b0; m_discard = 0; m_pc = '0;

        // Startup with 1-cycle memory
        do_reset();
        begin_cycle();
        chk1("lit_rst_req_valid", imem_req_valid, 1'b0);
        chk1("lit_rst_instr_valid", instr_valid, 1'b0);
        chk("lit_rst_instr", instr, 32'h0);
        chk("lit_rst_instr_pc", instr_pc, 32'h0);
        chk1("lit_rst_err", rsp_err, 1'b0);
        end_cycle();
        begin_cycle();
        chk1("lit_first_req", imem_req_valid, 1'b1);
        chk("lit_first_addr", imem_req_addr, 32'h0);
        end_cycle();
        begin_cycle();
        chk1("lit_valid_early", instr_valid, 1'b0);
        end_cycle();
        begin_cycle();
        chk1("lit_valid_2cyc", instr_valid, 1'b1);
        chk("lit_first_pc", instr_pc, 32'h0);
        end_cycle();
        repeat (6) tick();
        chk("lit_req1", qat(req_log, 1), 32'h4);
        chk("lit_req2", qat(req_log, 2), 32'h8);
        chk("lit_pop1", qat(pop_log, 1), 32'h4);
        chk("lit_pop2", qat(pop_log, 2), 32'h8);

        // Downstream stall
        do_reset();
        d_instr_ready = 1'b0;
        repeat (8) tick();
        chk("lit_stall_reqs", 32'(req_log.size()), 32'd2);
        d_instr_ready = 1'b1;
        pop_log.delete();
        begin_cycle();
        chk1("lit_stall_req_valid", imem_req_valid, 1'b0);
        chk("lit_stall_head", instr_pc, 32'h0);
        end_cycle();
        repeat (4) tick();
        chk("lit_rel_pop0", qat(pop_log, 0), 32'h0);
        chk("lit_rel_pop1", qat(pop_log, 1), 32'h4);
        chk("lit_rel_req2", qat(req_log, 2), 32'h8);

        // Redirect with two requests in flight, 3-cycle memory
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (3) tick();
        d_redir = 1'b1; d_redir_pc = 32'h0000_0103;
        tick();
        d_redir = 1'b0;
        req_log.delete();
        pop_log.delete();
        repeat (10) tick();
        chk("lit_redir_req", qat(req_log, 0), 32'h100);
        chk("lit_redir_pop", qat(pop_log, 0), 32'h100);

        // Unsolicited response sets the sticky error
        do_reset();
        lat_min = 1; lat_max = 1;
        d_req_ready = 1'b0;
        tick();
        d_unsol = 1'b1;
        tick();
        d_unsol = 1'b0;
        begin_cycle();
        chk1("lit_err_set", rsp_err, 1'b1);
        chk1("lit_err_fifo", instr_valid, 1'b0);
        end_cycle();
        repeat (5) tick();
        chk1("lit_err_sticky", rsp_err, 1'b1);
        d_rst_n = 1'b0;
        tick();
        begin_cycle();
        chk1("lit_err_clr", rsp_err, 1'b0);
        end_cycle();

        // PC wrap then mid-stream reset
        do_reset();
        d_req_ready = 1'b1;
        repeat (4) tick();
        d_redir = 1'b1; d_redir_pc = 32'hFFFF_FFF8;
        tick();
        d_redir = 1'b0;
        req_log.delete();
        repeat (8) tick();
        chk("lit_wrap0", qat(req_log, 0), 32'hFFFF_FFF8);
        chk("lit_wrap1", qat(req_log, 1), 32'hFFFF_FFFC);
        chk("lit_wrap2", qat(req_log, 2), 32'h0000_0000);
        d_rst_n = 1'b0;
        begin_cycle();
        chk1("lit_rst_mid_req", imem_req_valid, 1'b0);
        end_cycle();
        begin_cycle();
        chk1("lit_rst_mid_valid", instr_valid, 1'b0);
        chk("lit_rst_mid_pc", instr_pc, 32'h0);
        end_cycle();

        // Toggling request ready with 3-cycle memory
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 200; i++) begin
            d_req_ready = i[0];
            tick();
        end

        // Random traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 4000; i++) begin
            d_req_ready   = ($urandom_range(0, 3) != 0);
            d_instr_ready = ($urandom_range(0, 3) != 0);
            d_redir       = ($urandom_range(0, 39) == 0);
            d_redir_pc    = ($urandom_range(0, 3) == 0)
                          ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                          : $urandom;
            d_rst_n       = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
